// File: rtl/m_credit_tracker.sv
// ---------------------------------------------------------------------------
// m_credit_tracker
//
// Output-side credit bookkeeping for the 7 output channels of one router.
// Each channel counter holds the number of free slots in the downstream
// input buffer: it drops by one for every flit forwarded and rises by one
// for every credit the neighbour returns. The counts feed the adaptive
// diagonal choice in m_RoutingCalculation.
//
// After reset the tracker sits in LOAD for one edge, fills every counter
// with P_DEPTH, then runs. flush sends it back through the same sequence.
//
// Optional feature macro: CREDIT_ERRCHK_EN
//   defined   : sticky per-channel underflow/overflow error flags
//   undefined : err_underflow / err_overflow tied to 0, no flag registers
//
// Parameters:
//   P_DEPTH     downstream buffer depth, load value of every counter
//   P_LOCAL_ID  router id, informational only
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous reset, active-low
//   flush          in   synchronous re-initialisation request
//   flit_sent      in   [CHANNELS] one flit forwarded on channel i
//   credit_in      in   [CHANNELS] one credit returned on channel i
//   credits_0..6   out  [BUFFERSIZE_WIDTH] free-slot count per channel
//   avail          out  [CHANNELS] credits_i != 0
//   ready          out  tracker running, counts valid
//   err_underflow  out  [CHANNELS] sticky: send seen at 0 credits
//   err_overflow   out  [CHANNELS] sticky: credit seen at P_DEPTH credits
// ---------------------------------------------------------------------------
`ifndef CHANNELS
`define CHANNELS 7
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif

module m_credit_tracker #(
    parameter int P_DEPTH    = 4,
    parameter int P_LOCAL_ID = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic [`CHANNELS-1:0]         flit_sent,
    input  logic [`CHANNELS-1:0]         credit_in,
    output logic [`BUFFERSIZE_WIDTH-1:0] credits_0,
    output logic [`BUFFERSIZE_WIDTH-1:0] credits_1,
    output logic [`BUFFERSIZE_WIDTH-1:0] credits_2,
    output logic [`BUFFERSIZE_WIDTH-1:0] credits_3,
    output logic [`BUFFERSIZE_WIDTH-1:0] credits_4,
    output logic [`BUFFERSIZE_WIDTH-1:0] credits_5,
    output logic [`BUFFERSIZE_WIDTH-1:0] credits_6,
    output logic [`CHANNELS-1:0]         avail,
    output logic                         ready,
    output logic [`CHANNELS-1:0]         err_underflow,
    output logic [`CHANNELS-1:0]         err_overflow
);

    localparam int LP_CH = `CHANNELS;
    localparam int LP_W  = `BUFFERSIZE_WIDTH;
    localparam logic [LP_W-1:0] LP_DEPTH = LP_W'(P_DEPTH);

    // Elaboration-time sanity: the counter must be able to hold P_DEPTH and
    // the output list is hard-wired for seven channels.
    if (P_DEPTH < 1 || P_DEPTH > (2**LP_W) - 1 || LP_CH != 7 || P_LOCAL_ID < 0)
    begin : g_bad_param
        $error("m_credit_tracker: illegal parameterisation");
    end

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } t_state;

    t_state          r_state;
    logic            r_ready;
    logic [LP_W-1:0] r_count [LP_CH];

    // Saturating up/down step: simultaneous send and return cancel out,
    // and the count is pinned at 0 and P_DEPTH instead of wrapping.
    function automatic logic [LP_W-1:0] f_next_count(
        input logic [LP_W-1:0] cnt,
        input logic            sent,
        input logic            ret
    );
        logic [LP_W-1:0] nxt;
        nxt = cnt;
        if (sent && !ret && cnt != '0)
            nxt = cnt - LP_W'(1);
        else if (!sent && ret && cnt < LP_DEPTH)
            nxt = cnt + LP_W'(1);
        return nxt;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_LOAD;
            r_ready <= 1'b0;
            for (int i = 0; i < LP_CH; i++)
                r_count[i] <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // flush and channel events are ignored while loading
                    r_state <= S_RUN;
                    r_ready <= 1'b1;
                    for (int i = 0; i < LP_CH; i++)
                        r_count[i] <= LP_DEPTH;
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_LOAD;
                        r_ready <= 1'b0;
                        for (int i = 0; i < LP_CH; i++)
                            r_count[i] <= '0;
                    end else begin
                        for (int i = 0; i < LP_CH; i++)
                            r_count[i] <= f_next_count(r_count[i], flit_sent[i], credit_in[i]);
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign credits_0 = r_count[0];
    assign credits_1 = r_count[1];
    assign credits_2 = r_count[2];
    assign credits_3 = r_count[3];
    assign credits_4 = r_count[4];
    assign credits_5 = r_count[5];
    assign credits_6 = r_count[6];
    assign ready     = r_ready;

    always_comb begin
        avail = '0;
        for (int i = 0; i < LP_CH; i++)
            avail[i] = (r_count[i] != '0);
    end

`ifdef CREDIT_ERRCHK_EN
    logic [LP_CH-1:0] r_err_under;
    logic [LP_CH-1:0] r_err_over;
    logic [LP_CH-1:0] w_under_evt;
    logic [LP_CH-1:0] w_over_evt;

    // Error events only exist where the counter would have left its range;
    // a cancelling send+return pair is never an error.
    always_comb begin
        w_under_evt = '0;
        w_over_evt  = '0;
        for (int i = 0; i < LP_CH; i++) begin
            w_under_evt[i] = flit_sent[i] & ~credit_in[i] & (r_count[i] == '0);
            w_over_evt[i]  = ~flit_sent[i] & credit_in[i] & (r_count[i] == LP_DEPTH);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err_under <= '0;
            r_err_over  <= '0;
        end else if (r_state == S_RUN) begin
            if (flush) begin
                r_err_under <= '0;
                r_err_over  <= '0;
            end else begin
                r_err_under <= r_err_under | w_under_evt;
                r_err_over  <= r_err_over  | w_over_evt;
            end
        end
    end

    assign err_underflow = r_err_under;
    assign err_overflow  = r_err_over;
`else
    assign err_underflow = '0;
    assign err_overflow  = '0;
`endif

endmodule

// File: tb/tb_m_credit_tracker.sv
`ifndef CHANNELS
`define CHANNELS 7
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif

module tb_m_credit_tracker;

    localparam int W = `BUFFERSIZE_WIDTH;
`ifdef CREDIT_ERRCHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         CLK;
    logic         RST;
    logic         flush;
    logic [6:0]   flit_sent;
    logic [6:0]   credit_in;
    logic [W-1:0] credits_0, credits_1, credits_2, credits_3;
    logic [W-1:0] credits_4, credits_5, credits_6;
    logic [6:0]   avail;
    logic         ready;
    logic [6:0]   err_underflow;
    logic [6:0]   err_overflow;

    m_credit_tracker #(.P_DEPTH(4), .P_LOCAL_ID(0)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .flit_sent(flit_sent), .credit_in(credit_in),
        .credits_0(credits_0), .credits_1(credits_1), .credits_2(credits_2),
        .credits_3(credits_3), .credits_4(credits_4), .credits_5(credits_5),
        .credits_6(credits_6), .avail(avail), .ready(ready),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0]        sent;
        logic [6:0]        ret;
        logic              flush;
        logic [6:0][W-1:0] c;
        logic [6:0]        avail;
        logic              ready;
        logic [6:0]        under;
        logic [6:0]        over;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    logic [6:0][W-1:0] act_c;
    assign act_c = {credits_6, credits_5, credits_4, credits_3, credits_2, credits_1, credits_0};

    function automatic logic [6:0][W-1:0] pk(input int c0, c1, c2, c3, c4, c5, c6);
        logic [6:0][W-1:0] r;
        r[0] = W'(c0); r[1] = W'(c1); r[2] = W'(c2); r[3] = W'(c3);
        r[4] = W'(c4); r[5] = W'(c5); r[6] = W'(c6);
        return r;
    endfunction

    task automatic add(input logic [6:0] s, input logic [6:0] r, input logic f,
                       input logic [6:0][W-1:0] c, input logic [6:0] av,
                       input logic rdy, input logic [6:0] un, input logic [6:0] ov);
        vec_t v;
        v.sent = s; v.ret = r; v.flush = f; v.c = c; v.avail = av;
        v.ready = rdy; v.under = un; v.over = ov;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0][W-1:0] c,
                           input logic [6:0] av, input logic rdy,
                           input logic [6:0] un, input logic [6:0] ov);
        chk({tag, ".credits"}, 64'(act_c), 64'(c));
        chk({tag, ".avail"},   64'(avail), 64'(av));
        chk({tag, ".ready"},   64'(ready), 64'(rdy));
        chk({tag, ".err_underflow"}, 64'(err_underflow), ERR_EN ? 64'(un) : 64'd0);
        chk({tag, ".err_overflow"},  64'(err_overflow),  ERR_EN ? 64'(ov) : 64'd0);
    endtask

    initial begin
        logic [6:0][W-1:0] z;
        logic [6:0][W-1:0] f4;
        z  = pk(0, 0, 0, 0, 0, 0, 0);
        f4 = pk(4, 4, 4, 4, 4, 4, 4);

        // sent, ret, flush, credits c0..c6, avail, ready, err_under, err_over
        add(7'h08, 7'h00, 0, pk(4,4,4,3,4,4,4), 7'h7F, 1, 7'h00, 7'h00);
        add(7'h08, 7'h00, 0, pk(4,4,4,2,4,4,4), 7'h7F, 1, 7'h00, 7'h00);
        add(7'h08, 7'h00, 0, pk(4,4,4,1,4,4,4), 7'h7F, 1, 7'h00, 7'h00);
        add(7'h08, 7'h00, 0, pk(4,4,4,0,4,4,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h20, 7'h00, 0, pk(4,4,4,0,4,3,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h20, 7'h00, 0, pk(4,4,4,0,4,2,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h20, 7'h20, 0, pk(4,4,4,0,4,2,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h00, 7'h20, 0, pk(4,4,4,0,4,3,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h02, 7'h00, 0, pk(4,3,4,0,4,3,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h02, 7'h00, 0, pk(4,2,4,0,4,3,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h02, 7'h00, 0, pk(4,1,4,0,4,3,4), 7'h77, 1, 7'h00, 7'h00);
        add(7'h02, 7'h00, 0, pk(4,0,4,0,4,3,4), 7'h75, 1, 7'h00, 7'h00);
        add(7'h02, 7'h00, 0, pk(4,0,4,0,4,3,4), 7'h75, 1, 7'h02, 7'h00);
        add(7'h00, 7'h00, 0, pk(4,0,4,0,4,3,4), 7'h75, 1, 7'h02, 7'h00);
        add(7'h00, 7'h40, 0, pk(4,0,4,0,4,3,4), 7'h75, 1, 7'h02, 7'h40);
        add(7'h08, 7'h08, 0, pk(4,0,4,0,4,3,4), 7'h75, 1, 7'h02, 7'h40);
        add(7'h00, 7'h08, 0, pk(4,0,4,1,4,3,4), 7'h7D, 1, 7'h02, 7'h40);
        add(7'h7F, 7'h00, 1, z,                 7'h00, 0, 7'h00, 7'h00);
        add(7'h00, 7'h00, 0, f4,                7'h7F, 1, 7'h00, 7'h00);
        add(7'h00, 7'h00, 1, z,                 7'h00, 0, 7'h00, 7'h00);
        add(7'h00, 7'h00, 1, f4,                7'h7F, 1, 7'h00, 7'h00);
        add(7'h01, 7'h00, 0, pk(3,4,4,4,4,4,4), 7'h7F, 1, 7'h00, 7'h00);
        add(7'h00, 7'h00, 1, z,                 7'h00, 0, 7'h00, 7'h00);
        add(7'h7F, 7'h00, 0, f4,                7'h7F, 1, 7'h00, 7'h00);
        add(7'h00, 7'h01, 0, f4,                7'h7F, 1, 7'h00, 7'h01);

        RST = 1'b0; flush = 1'b0; flit_sent = '0; credit_in = '0;

        // Reset held across clock edges: everything stays cleared.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all("reset", z, 7'h00, 0, 7'h00, 7'h00);

        // First edge after release loads the counters.
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk_all("release", f4, 7'h7F, 1, 7'h00, 7'h00);

        foreach (vq[k]) begin
            flit_sent = vq[k].sent;
            credit_in = vq[k].ret;
            flush     = vq[k].flush;
            @(posedge CLK);
            @(negedge CLK);
            chk_all($sformatf("vec%0d", k), vq[k].c, vq[k].avail, vq[k].ready,
                    vq[k].under, vq[k].over);
        end
        flit_sent = '0; credit_in = '0; flush = 1'b0;

        // Build up some state, then drop RST between clock edges.
        flit_sent = 7'h7F;
        credit_in = 7'h01;
        @(posedge CLK);
        @(negedge CLK);
        flit_sent = '0; credit_in = '0;
        chk_all("pre_async", pk(4,3,3,3,3,3,3), 7'h7F, 1, 7'h00, 7'h01);
        #1 RST = 1'b0;
        #1;
        chk_all("async_rst", z, 7'h00, 0, 7'h00, 7'h00);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk_all("async_reload", f4, 7'h7F, 1, 7'h00, 7'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m_credit_tracker.md
Name: m_credit_tracker

Overview:
- Per-router output-side credit bookkeeping for the 7 output channels.
- Tracks free slots in each downstream input buffer: decrements on every flit forwarded, increments on every credit returned by the neighbour.
- Drives credits_0..credits_6, which m_RoutingCalculation uses for its adaptive diagonal choice.
- One instance per router, between the switch traversal stage and the routing calculation.

Parameters:
- P_DEPTH, 4, downstream buffer depth in flits and the value loaded into every counter. Must be ≤ 2^`BUFFERSIZE_WIDTH − 1.
- P_LOCAL_ID, 0, router id; informational only, no behavioural effect.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low (0 = reset).
- flush  input  1  synchronous re-initialisation request.
- flit_sent  input  `CHANNELS  bit i = one flit forwarded on output channel i this cycle.
- credit_in  input  `CHANNELS  bit i = one credit returned by the downstream router on channel i this cycle.
- credits_0 … credits_6  output  `BUFFERSIZE_WIDTH each  current free-slot count per channel.
- avail  output  `CHANNELS  bit i = credits_i != 0.
- ready  output  1  tracker in RUN state, counts valid.
- err_underflow  output  `CHANNELS  sticky: send attempted at 0 credits.
- err_overflow  output  `CHANNELS  sticky: credit returned at P_DEPTH credits.

Behaviour:
- Reset (RST=0, asynchronous):
  - All counters 0, so credits_0..6 = 0 and avail = 0.
  - ready = 0; err_* = 0; state = LOAD.
- States: LOAD and RUN.
  - LOAD: on the next rising edge, all counters ← P_DEPTH, ready ← 1, state ← RUN. flit_sent and credit_in are ignored in LOAD.
  - RUN, flush=1: counters ← 0, err_* ← 0, ready ← 0, state ← LOAD. flush has priority over flit_sent and credit_in in the same cycle.
  - RUN, flush=0: each channel i is updated independently, as below.
- Per-channel update in RUN (channel i):
  - sent=1, ret=0, count>0: count − 1.
  - sent=0, ret=1, count<P_DEPTH: count + 1.
  - sent=1 and ret=1: count unchanged, at any count value including 0 and P_DEPTH. No error flagged.
  - sent=1, ret=0, count=0: count stays 0 (no wrap); underflow event.
  - sent=0, ret=1, count=P_DEPTH: count stays P_DEPTH (saturate); overflow event.
- Latency: events in cycle N are visible on credits_i and avail in cycle N+1. Outputs are driven straight from registers; avail is decoded combinationally from the counter registers.
- Arithmetic: unsigned, `BUFFERSIZE_WIDTH bits. Counters never wrap.
- flush while already in LOAD: no effect; the load proceeds.
- RST asserted mid-operation: outputs clear immediately, without waiting for a clock edge. The LOAD → RUN sequence restarts after RST is released.

Optional Feature:
- Macro: CREDIT_ERRCHK_EN.
- Defined:
  - An underflow event sets err_underflow[i]; an overflow event sets err_overflow[i].
  - Both flags are sticky until RST or flush.
- Undefined:
  - err_underflow and err_overflow are tied to 0; no error registers are synthesised.
  - Counter saturation behaviour is unchanged.

Test Plan:
- Reset release, P_DEPTH=4: while RST=0, credits_0..6=0, avail=0, ready=0. First edge after release → all credits=4, avail=7'h7F, ready=1.
- flit_sent[3]=1 for 4 consecutive cycles: credits_3 goes 4→3→2→1→0, one cycle behind each send. avail[3]=0 after the fourth send; other channels remain at 4.
- credits_5=2, then flit_sent[5]=1 and credit_in[5]=1 in the same cycle: credits_5 stays 2 and no error flag is set. Next cycle credit_in[5]=1 alone: credits_5=3.
- credits_1=0, flit_sent[1]=1: credits_1 stays 0. With CREDIT_ERRCHK_EN, err_underflow=7'h02 and holds after the input drops; without it, err_underflow=0.
- credits_6=4, credit_in[6]=1: credits_6 stays 4. With CREDIT_ERRCHK_EN, err_overflow=7'h40.
- In RUN, pulse flush together with flit_sent=7'h7F: next cycle credits all 0, ready=0, err_* cleared; the cycle after, all credits=4 and ready=1. Separately, dropping RST mid-cycle clears all outputs before the next clock edge.
